dual_slope_ctrl: RTL and testbench

DUAL_SLOPE_CTRL -- requirements
Module: dual_slope_ctrl

---
 rtl/dual_slope_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_dual_slope_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dual_slope_ctrl.sv
// Dual-slope ADC sequencer.
// Drives the analog front end through auto-zero, integrate and de-integrate,
// steps the range up when the front end saturates, and reports the
// de-integrate count together with polarity, range and overrange.
module dual_slope_ctrl #(
    parameter int T_AZ        = 1000,
    parameter int T_INT       = 10000,
    parameter int T_DEINT_MAX = 20000,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic             ref_ok_i,
    input  logic             comp_i,
    input  logic             sat_hi_i,
    input  logic             sat_lo_i,
    output logic [1:0]       afe_sel_o,
    output logic [2:0]       range_sel_o,
    output logic             afe_reset_o,
    output logic             ref_sign_o,
    output logic [1:0]       mode_sel_o,
    output logic [CNT_W-1:0] result_o,
    output logic             sign_o,
    output logic [2:0]       range_o,
    output logic             valid_o,
    output logic             ovf_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_REF = 3'd1,
        S_AZ       = 3'd2,
        S_INT      = 3'd3,
        S_DEINT    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    // Terminal counts: a phase of N cycles ends in the cycle the counter shows N-1.
    localparam logic [CNT_W-1:0] AZ_LAST    = CNT_W'(T_AZ - 1);
    localparam logic [CNT_W-1:0] INT_LAST   = CNT_W'(T_INT - 1);
    localparam logic [CNT_W-1:0] DEINT_LAST = CNT_W'(T_DEINT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [2:0]       RANGE_MAX  = 3'd7;

    // Synchronizer bit order: {sat_lo, sat_hi, comp, ref_ok}
    logic [3:0] meta_q;
    logic [3:0] sync_q;
    logic       ref_ok_s;
    logic       comp_s;
    logic       sat_s;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [2:0]       range_sel_q, range_sel_d;
    logic             ref_sign_q,  ref_sign_d;
    logic [1:0]       mode_sel_q,  mode_sel_d;
    logic [CNT_W-1:0] result_q,    result_d;
    logic             sign_q,      sign_d;
    logic [2:0]       range_q,     range_d;
    logic             ovf_q,       ovf_d;
    logic             valid_q,     valid_d;
    logic             busy_q,      busy_d;
    logic [1:0]       afe_sel_q,   afe_sel_d;
    logic             afe_reset_q, afe_reset_d;

    // Two-flop synchronizers for the asynchronous front-end status lines.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {sat_lo_i, sat_hi_i, comp_i, ref_ok_i};
            sync_q <= meta_q;
        end
    end

    assign ref_ok_s = sync_q[0];
    assign comp_s   = sync_q[1];
    assign sat_s    = sync_q[2] | sync_q[3];

    // Phase counter advances by one and sticks at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Next-state, counter and result-capture logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        range_sel_d = range_sel_q;
        ref_sign_d  = ref_sign_q;
        mode_sel_d  = mode_sel_q;
        result_d    = result_q;
        sign_d      = sign_q;
        range_d     = range_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_WAIT_REF;
                    mode_sel_d  = mode_i;
                    range_sel_d = 3'd0;
                end
            end

            S_WAIT_REF: begin
                if (ref_ok_s) begin
                    state_d = S_AZ;
                    cnt_d   = '0;
                end
            end

            // Reference loss wins over everything; saturation wins over the
            // phase end so that a saturated reading is never integrated on.
            S_AZ, S_INT: begin
                if (!ref_ok_s) begin
                    state_d = S_WAIT_REF;
                    cnt_d   = '0;
                end else if (sat_s) begin
                    if (range_sel_q != RANGE_MAX) begin
                        state_d     = S_AZ;
                        cnt_d       = '0;
                        range_sel_d = range_sel_q + 3'd1;
                    end else begin
                        state_d  = S_DONE;
                        result_d = '1;
                        ovf_d    = 1'b1;
                    end
                end else if (state_q == S_AZ) begin
                    if (cnt_q == AZ_LAST) begin
                        state_d = S_INT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    if (cnt_q == INT_LAST) begin
                        // Integrator polarity picks the opposing reference.
                        state_d    = S_DEINT;
                        cnt_d      = '0;
                        ref_sign_d = comp_s;
                        sign_d     = comp_s;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end

            // Saturation is deliberately not looked at while de-integrating.
            S_DEINT: begin
                if (!ref_ok_s) begin
                    state_d = S_WAIT_REF;
                    cnt_d   = '0;
                end else if (comp_s != ref_sign_q) begin
                    state_d  = S_DONE;
                    result_d = cnt_q;
                    ovf_d    = 1'b0;
                end else if (cnt_q == DEINT_LAST) begin
                    state_d  = S_DONE;
                    result_d = DEINT_LAST;
                    ovf_d    = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // The range reported alongside a result is the one it was taken on.
        if (state_d == S_DONE) begin
            range_d = range_sel_q;
        end
    end

    // Outputs are decoded from the next state so the registered copies line
    // up with the state register cycle for cycle.
    always_comb begin
        afe_sel_d   = 2'b00;
        afe_reset_d = 1'b0;
        busy_d      = (state_d != S_IDLE);
        valid_d     = (state_d == S_DONE);
        case (state_d)
            S_AZ:    afe_sel_d = 2'b01;
            S_INT:   afe_sel_d = 2'b10;
            S_DEINT: afe_sel_d = 2'b11;
            default: afe_sel_d = 2'b00;
        endcase
        if (state_d == S_IDLE || state_d == S_WAIT_REF || state_d == S_DONE) begin
            afe_reset_d = 1'b1;
        end
    end

    // State, counter and output registers; reset aborts any conversion at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            range_sel_q <= 3'd0;
            ref_sign_q  <= 1'b0;
            mode_sel_q  <= 2'b00;
            result_q    <= '0;
            sign_q      <= 1'b0;
            range_q     <= 3'd0;
            ovf_q       <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            afe_sel_q   <= 2'b00;
            afe_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            range_sel_q <= range_sel_d;
            ref_sign_q  <= ref_sign_d;
            mode_sel_q  <= mode_sel_d;
            result_q    <= result_d;
            sign_q      <= sign_d;
            range_q     <= range_d;
            ovf_q       <= ovf_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            afe_sel_q   <= afe_sel_d;
            afe_reset_q <= afe_reset_d;
        end
    end

    assign afe_sel_o   = afe_sel_q;
    assign range_sel_o = range_sel_q;
    assign afe_reset_o = afe_reset_q;
    assign ref_sign_o  = ref_sign_q;
    assign mode_sel_o  = mode_sel_q;
    assign result_o    = result_q;
    assign sign_o      = sign_q;
    assign range_o     = range_q;
    assign valid_o     = valid_q;
    assign ovf_o       = ovf_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Directed testbench for dual_slope_ctrl with short phase lengths.
module tb_dual_slope_ctrl;

    localparam int CNT_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [1:0]       mode_i;
    logic             ref_ok_i;
    logic             comp_i;
    logic             sat_hi_i;
    logic             sat_lo_i;
    logic [1:0]       afe_sel_o;
    logic [2:0]       range_sel_o;
    logic             afe_reset_o;
    logic             ref_sign_o;
    logic [1:0]       mode_sel_o;
    logic [CNT_W-1:0] result_o;
    logic             sign_o;
    logic [2:0]       range_o;
    logic             valid_o;
    logic             ovf_o;
    logic             busy_o;

    int checks   = 0;
    int failures = 0;
    int vcount   = 0;

    dual_slope_ctrl #(
        .T_AZ(4), .T_INT(8), .T_DEINT_MAX(16), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
        .ref_ok_i(ref_ok_i), .comp_i(comp_i), .sat_hi_i(sat_hi_i), .sat_lo_i(sat_lo_i),
        .afe_sel_o(afe_sel_o), .range_sel_o(range_sel_o), .afe_reset_o(afe_reset_o),
        .ref_sign_o(ref_sign_o), .mode_sel_o(mode_sel_o), .result_o(result_o),
        .sign_o(sign_o), .range_o(range_o), .valid_o(valid_o), .ovf_o(ovf_o),
        .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Count result strobes, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (valid_o === 1'b1) vcount++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_sel(input logic [1:0] s, input int budget);
        int n;
        n = 0;
        while (afe_sel_o !== s && n < budget) begin
            tick();
            n++;
        end
        if (afe_sel_o !== s) check("wait_sel_timeout", afe_sel_o, s);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Runs until valid_o, counting cycles spent in each AFE phase. comp_i is
    // inverted in the de-integrate cycle numbered flip_at and start_i is
    // pulsed in the one numbered start_at (-1 disables either).
    task automatic run_conv(input int flip_at, input int start_at,
                            output int n_az, output int n_int, output int n_deint);
        bit got;
        got = 1'b0;
        n_az = 0;
        n_int = 0;
        n_deint = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            tick();
            start_i = 1'b0;
            case (afe_sel_o)
                2'b01: n_az++;
                2'b10: n_int++;
                2'b11: begin
                    if (n_deint == flip_at) comp_i = ~comp_i;
                    if (n_deint == start_at) start_i = 1'b1;
                    n_deint++;
                end
                default: ;
            endcase
            if (valid_o === 1'b1) got = 1'b1;
        end
        check("valid_seen", got, 1);
    endtask

    initial begin
        int n_az, n_int, n_deint, v0, steps, int_idx;
        logic [1:0] prev;
        bit got;

        rst_i = 1'b1; start_i = 1'b0; mode_i = 2'b00; ref_ok_i = 1'b1;
        comp_i = 1'b0; sat_hi_i = 1'b0; sat_lo_i = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_afe_sel", afe_sel_o, 2'b00);
        check("rst_afe_reset", afe_reset_o, 1);
        check("rst_busy", busy_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_result", result_o, 0);
        check("rst_range_sel", range_sel_o, 0);
        check("rst_mode_sel", mode_sel_o, 0);
        check("rst_ovf", ovf_o, 0);
        rst_i = 1'b0;
        repeat (5) tick();
        check("idle_busy", busy_o, 0);

        // Positive input, comparator crosses 5 cycles into de-integrate
        comp_i = 1'b1;
        mode_i = 2'b10;
        pulse_start();
        mode_i = 2'b01;
        check("t1_waitref_sel", afe_sel_o, 2'b00);
        check("t1_waitref_busy", busy_o, 1);
        run_conv(5, -1, n_az, n_int, n_deint);
        check("t1_n_az", n_az, 4);
        check("t1_n_int", n_int, 8);
        check("t1_n_deint", n_deint, 8);
        check("t1_result", result_o, 7);
        check("t1_sign", sign_o, 1);
        check("t1_ref_sign", ref_sign_o, 1);
        check("t1_ovf", ovf_o, 0);
        check("t1_range", range_o, 0);
        check("t1_mode_sel", mode_sel_o, 2'b10);
        tick();
        check("t1_valid_width", valid_o, 0);
        check("t1_idle_busy", busy_o, 0);

        // Negative input, no crossing: timeout
        comp_i = 1'b0;
        repeat (3) tick();
        pulse_start();
        run_conv(-1, -1, n_az, n_int, n_deint);
        check("t2_n_deint", n_deint, 16);
        check("t2_result", result_o, 15);
        check("t2_ovf", ovf_o, 1);
        check("t2_sign", sign_o, 0);
        tick();

        // Negative input, crossing right at de-integrate start
        comp_i = 1'b0;
        repeat (3) tick();
        pulse_start();
        run_conv(0, -1, n_az, n_int, n_deint);
        check("t3_n_deint", n_deint, 3);
        check("t3_result", result_o, 2);
        check("t3_ovf", ovf_o, 0);
        check("t3_sign", sign_o, 0);
        tick();

        // Autorange through all ranges, then overrange at range 7
        comp_i = 1'b1;
        repeat (3) tick();
        pulse_start();
        prev = 2'b00; int_idx = 0; steps = 0; got = 1'b0;
        for (int i = 0; i < 600 && !got; i++) begin
            tick();
            sat_hi_i = 1'b0;
            sat_lo_i = 1'b0;
            if (afe_sel_o == 2'b10) begin
                if (prev != 2'b10) int_idx = 0;
                if (int_idx == 2) begin
                    if (steps[0]) sat_lo_i = 1'b1;
                    else          sat_hi_i = 1'b1;
                end
                int_idx++;
            end
            if (afe_sel_o == 2'b01 && prev == 2'b10) begin
                steps++;
                check("t4_range_step", range_sel_o, steps);
            end
            if (valid_o === 1'b1) got = 1'b1;
            prev = afe_sel_o;
        end
        check("t4_valid_seen", got, 1);
        check("t4_steps", steps, 7);
        check("t4_ovf", ovf_o, 1);
        check("t4_result", result_o, 16'hFFFF);
        check("t4_range", range_o, 7);
        tick();

        // Reference loss during integrate at range 1, then recovery;
        // start pulsed during de-integrate must be ignored
        comp_i = 1'b1;
        repeat (3) tick();
        pulse_start();
        check("t5_new_range", range_sel_o, 0);
        wait_sel(2'b10, 20);
        repeat (2) tick();
        sat_hi_i = 1'b1;
        tick();
        sat_hi_i = 1'b0;
        wait_sel(2'b01, 10);
        check("t5_range_after_sat", range_sel_o, 1);
        wait_sel(2'b10, 10);
        tick();
        ref_ok_i = 1'b0;
        v0 = vcount;
        wait_sel(2'b00, 10);
        check("t5_abort_busy", busy_o, 1);
        check("t5_abort_range", range_sel_o, 1);
        check("t5_abort_afe_reset", afe_reset_o, 1);
        repeat (4) tick();
        check("t5_hold_sel", afe_sel_o, 2'b00);
        check("t5_no_valid", vcount, v0);
        ref_ok_i = 1'b1;
        run_conv(5, 2, n_az, n_int, n_deint);
        check("t5_n_az", n_az, 4);
        check("t5_n_int", n_int, 8);
        check("t5_n_deint", n_deint, 8);
        check("t5_result", result_o, 7);
        check("t5_range", range_o, 1);
        check("t5_ovf", ovf_o, 0);
        tick();
        check("t5_valid_count", vcount, v0 + 1);
        tick();
        check("t5_start_ignored", busy_o, 0);

        // Asynchronous reset in the middle of integrate
        comp_i = 1'b1;
        mode_i = 2'b11;
        repeat (3) tick();
        pulse_start();
        wait_sel(2'b10, 20);
        repeat (3) tick();
        v0 = vcount;
        #2 rst_i = 1'b1;
        #1;
        check("t6_afe_sel", afe_sel_o, 2'b00);
        check("t6_afe_reset", afe_reset_o, 1);
        check("t6_busy", busy_o, 0);
        check("t6_valid", valid_o, 0);
        check("t6_result", result_o, 0);
        check("t6_sign", sign_o, 0);
        check("t6_range", range_o, 0);
        check("t6_range_sel", range_sel_o, 0);
        check("t6_mode_sel", mode_sel_o, 2'b00);
        check("t6_ref_sign", ref_sign_o, 0);
        check("t6_ovf", ovf_o, 0);
        repeat (2) tick();
        rst_i = 1'b0;
        repeat (5) tick();
        check("t6_idle_sel", afe_sel_o, 2'b00);
        check("t6_idle_busy", busy_o, 0);
        check("t6_no_valid", vcount, v0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
